muldiv_control: RTL and testbench
=================================

// Module: muldiv_control
// PURPOSE
//  Parametrised multiply/divide decode and execution unit for the EX stage; companion to the single-cycle ALU decoder.
//  Decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO (opcode 6'h0), runs an iterative shift-add multiplier and a
//  restoring divider, owns the HI/LO registers and stalls the pipeline while a result is pending.
// PARAMETERS
//  DATA_W    32  operand/HI/LO width (>=4)
//  FAST_MUL  0   1: single-cycle multiply (combinational *); 0: iterative, DATA_W cycles
// PORTS
//  i_clk            in   1       clock, rising edge
//  i_rst            in   1       asynchronous reset, active-high
//  i_valid          in   1       instruction present in EX this cycle
//  i_aluOp          in   6       opcode field
//  i_func           in   6       function field
//  i_rs             in   DATA_W  operand A (dividend / multiplicand / MTHI/MTLO source)
//  i_rt             in   DATA_W  operand B (divisor / multiplier)
//  i_flush          in   1       abort in-flight op (exception/ERET)
//  o_stall          out  1       hold EX and earlier stages (combinational)
//  o_busy           out  1       engine occupied (registered)
//  o_result         out  DATA_W  HI or LO for MFHI/MFLO
//  o_result_valid   out  1       o_result valid this cycle
//  o_unknown_func   out  1       unsupported func in 6'b01xxxx group (combinational)
//  o_div_by_zero    out  1       one-cycle pulse at writeback of a zero-divisor DIV/DIVU
// BEHAVIOUR
//  - Reset: HI=LO=0, state IDLE, counter 0, o_busy=0, o_div_by_zero=0; combinational outputs 0 with i_valid=0.
//  - Func: MFHI 6'h10, MTHI 6'h11, MFLO 6'h12, MTLO 6'h13, MULT 6'h18, MULTU 6'h19, DIV 6'h1A, DIVU 6'h1B.
//    Decode only when i_aluOp==6'h0 and i_valid; other func in 6'b01xxxx -> o_unknown_func=1, no action.
//  - FSM IDLE -> RUN -> FIX -> IDLE. Accept in IDLE when i_valid & MULT*/DIV* & ~i_flush (cycle 0):
//    latch |rs|,|rt| (signed ops) or raw (unsigned), latch sign flags, counter=DATA_W.
//    RUN: one quotient/product bit per cycle, counter-1; leave when counter reaches 0.
//    FIX: apply sign correction, write HI/LO, -> IDLE.
//  - Latency: iterative op busy cycles 1..DATA_W+1, HI/LO updated at end of cycle DATA_W+1.
//    FAST_MUL=1 multiply: skip RUN, FIX in cycle 1. Divide by zero: skip RUN, FIX in cycle 1.
//  - Sign rules: product negated if signs differ (2*DATA_W wide); quotient negated if signs differ;
//    remainder takes sign of dividend. MIN_INT / -1: LO=MIN_INT, HI=0 (wrap, no flag).
//  - Divide by zero (both DIV/DIVU): LO={DATA_W{1'b1}}, HI=i_rs as latched, o_div_by_zero=1 during FIX cycle.
//  - o_busy = state!=IDLE. o_stall = i_valid & (MFHI|MFLO|MTHI|MTLO|MULT*|DIV*) & o_busy & ~i_flush.
//  - MFHI/MFLO when not stalled: o_result=HI/LO (current register value), o_result_valid=1, same cycle.
//  - MTHI/MTLO when not stalled: HI/LO<=i_rs at clock edge.
//  - FIX-cycle writeback and MF* in same cycle: MF* stalls (busy) and reads the new value next cycle.
//  - i_flush: any state -> IDLE next edge, HI/LO unchanged, no div_by_zero pulse; flush beats accept.
//  - Reset mid-operation: immediate IDLE, HI=LO=0, no writeback.
//  - Wrap-around: all arithmetic modulo 2^DATA_W per register; no overflow traps.
// TESTING (DATA_W=32, FAST_MUL=0 unless stated)
//  1. MULTU rs=32'hFFFFFFFF rt=2 -> o_busy 33 cycles, then HI=1, LO=32'hFFFFFFFE; MFLO during busy stalls.
//  2. MULT rs=-3 rt=5 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFF1; FAST_MUL=1 same result after 1 busy cycle.
//  3. DIV rs=-7 rt=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; DIV 32'h80000000 / -1 -> LO=32'h80000000, HI=0.
//  4. DIVU rs=9 rt=0 -> o_busy 1 cycle, LO=32'hFFFFFFFF, HI=9, o_div_by_zero single pulse.
//  5. MTHI 32'hA5A5A5A5 then MULT; i_flush at cycle 10 -> IDLE next cycle, MFHI returns 32'hA5A5A5A5.
//  6. i_rst at cycle 5 of DIVU -> HI=LO=0, o_busy=0 immediately; func 6'h1C -> o_unknown_func=1, no state change.

Source files
------------

// File: rtl/muldiv_control.sv
// muldiv_control: HI/LO register owner for the EX stage.
// Decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO, runs an iterative
// shift-add multiplier or a restoring divider, and stalls the pipeline
// while a result is pending. With FAST_MUL != 0, multiplies complete through
// a combinational product in a single fix-up cycle.
module muldiv_control #(
  parameter int DATA_W   = 32,
  parameter int FAST_MUL = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [5:0]        i_aluOp,
  input  logic [5:0]        i_func,
  input  logic [DATA_W-1:0] i_rs,
  input  logic [DATA_W-1:0] i_rt,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_busy,
  output logic [DATA_W-1:0] o_result,
  output logic              o_result_valid,
  output logic              o_unknown_func,
  output logic              o_div_by_zero
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  // acc holds the upper product half (multiply) or the partial remainder (divide)
  logic [DATA_W-1:0] acc_reg, acc_next;
  // quo holds the multiplier/lower product half or the dividend/quotient bits
  logic [DATA_W-1:0] quo_reg, quo_next;
  // opnd holds the multiplicand or divisor magnitude
  logic [DATA_W-1:0] opnd_reg, opnd_next;
  logic              is_div_reg, is_div_next;
  logic              neg_q_reg, neg_q_next;
  logic              neg_r_reg, neg_r_next;
  logic              dz_reg, dz_next;
  logic [DATA_W-1:0] hi_reg, hi_next;
  logic [DATA_W-1:0] lo_reg, lo_next;

  // Decoded instruction flags
  logic dec_en;
  logic is_mfhi, is_mthi, is_mflo, is_mtlo;
  logic is_mult, is_multu, is_div, is_divu;
  logic is_muldiv, is_hilo_op, is_known;

  // Operand preparation at accept time
  logic              signed_op;
  logic              a_neg, b_neg, b_zero;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic              accept;

  // Datapath step and fix-up values
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     rem_shift;
  logic [DATA_W:0]     rem_sub;
  logic                div_ge;
  logic [2*DATA_W-1:0] prod_raw;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  // Instruction decode: only opcode 0 with a valid instruction is considered
  always_comb begin
    dec_en     = i_valid && (i_aluOp == 6'h00);
    is_mfhi    = dec_en && (i_func == FN_MFHI);
    is_mthi    = dec_en && (i_func == FN_MTHI);
    is_mflo    = dec_en && (i_func == FN_MFLO);
    is_mtlo    = dec_en && (i_func == FN_MTLO);
    is_mult    = dec_en && (i_func == FN_MULT);
    is_multu   = dec_en && (i_func == FN_MULTU);
    is_div     = dec_en && (i_func == FN_DIV);
    is_divu    = dec_en && (i_func == FN_DIVU);
    is_muldiv  = is_mult || is_multu || is_div || is_divu;
    is_hilo_op = is_mfhi || is_mflo || is_mthi || is_mtlo || is_muldiv;
    is_known   = is_hilo_op;
  end

  // Operand magnitudes and sign flags; unsigned ops use the raw operands
  always_comb begin
    signed_op = is_mult || is_div;
    a_neg     = signed_op && i_rs[DATA_W-1];
    b_neg     = signed_op && i_rt[DATA_W-1];
    a_mag     = a_neg ? (~i_rs + 1'b1) : i_rs;
    b_mag     = b_neg ? (~i_rt + 1'b1) : i_rt;
    b_zero    = (i_rt == '0);
    accept    = (state_reg == ST_IDLE) && is_muldiv && !i_flush;
  end

  // One iteration of the shift-add multiplier and of the restoring divider
  always_comb begin
    mul_sum   = {1'b0, acc_reg} + (quo_reg[0] ? {1'b0, opnd_reg} : {(DATA_W+1){1'b0}});
    rem_shift = {acc_reg, quo_reg[DATA_W-1]};
    div_ge    = (rem_shift >= {1'b0, opnd_reg});
    rem_sub   = rem_shift - {1'b0, opnd_reg};
  end

  // Raw product: combinational multiplier or the accumulated shift-add result
  generate
    if (FAST_MUL != 0) begin : g_fast_mul
      assign prod_raw = {{DATA_W{1'b0}}, quo_reg} * {{DATA_W{1'b0}}, opnd_reg};
    end else begin : g_iter_mul
      assign prod_raw = {acc_reg, quo_reg};
    end
  endgenerate

  // Sign correction: product/quotient negated on differing signs,
  // remainder follows the dividend
  always_comb begin
    prod_fix = neg_q_reg ? (~prod_raw + 1'b1) : prod_raw;
    quo_fix  = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
    rem_fix  = neg_r_reg ? (~acc_reg + 1'b1) : acc_reg;
  end

  // Next-state and datapath update; a flush returns to IDLE and holds HI/LO
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    quo_next    = quo_reg;
    opnd_next   = opnd_reg;
    is_div_next = is_div_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    dz_next     = dz_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;

    if (i_flush) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      dz_next    = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            opnd_next   = b_mag;
            acc_next    = '0;
            is_div_next = is_div || is_divu;
            neg_q_next  = a_neg ^ b_neg;
            neg_r_next  = a_neg;
            dz_next     = (is_div || is_divu) && b_zero;
            cnt_next    = CNT_W'(DATA_W);
            // A zero divisor keeps the raw dividend so HI can return it
            quo_next    = ((is_div || is_divu) && b_zero) ? i_rs : a_mag;
            if (((is_div || is_divu) && b_zero) ||
                ((is_mult || is_multu) && (FAST_MUL != 0))) begin
              state_next = ST_FIX;
            end else begin
              state_next = ST_RUN;
            end
          end else begin
            // Moves into HI/LO only happen while idle (otherwise they stall)
            if (is_mthi) hi_next = i_rs;
            if (is_mtlo) lo_next = i_rs;
          end
        end

        ST_RUN: begin
          if (is_div_reg) begin
            acc_next = div_ge ? rem_sub[DATA_W-1:0] : rem_shift[DATA_W-1:0];
            quo_next = {quo_reg[DATA_W-2:0], div_ge};
          end else begin
            acc_next = mul_sum[DATA_W:1];
            quo_next = {mul_sum[0], quo_reg[DATA_W-1:1]};
          end
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) begin
            state_next = ST_FIX;
          end
        end

        ST_FIX: begin
          if (dz_reg) begin
            hi_next = quo_reg;
            lo_next = '1;
          end else if (is_div_reg) begin
            hi_next = rem_fix;
            lo_next = quo_fix;
          end else begin
            hi_next = prod_fix[2*DATA_W-1:DATA_W];
            lo_next = prod_fix[DATA_W-1:0];
          end
          dz_next    = 1'b0;
          state_next = ST_IDLE;
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers, cleared by the asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      quo_reg    <= '0;
      opnd_reg   <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dz_reg     <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      quo_reg    <= quo_next;
      opnd_reg   <= opnd_next;
      is_div_reg <= is_div_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      dz_reg     <= dz_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
    end
  end

  // Pipeline-facing status and read port
  always_comb begin
    o_busy         = (state_reg != ST_IDLE);
    o_stall        = is_hilo_op && o_busy && !i_flush;
    o_unknown_func = dec_en && (i_func[5:4] == 2'b01) && !is_known;
    o_div_by_zero  = (state_reg == ST_FIX) && dz_reg && !i_flush;
    o_result_valid = 1'b0;
    o_result       = '0;
    if (!o_stall) begin
      if (is_mfhi) begin
        o_result_valid = 1'b1;
        o_result       = hi_reg;
      end else if (is_mflo) begin
        o_result_valid = 1'b1;
        o_result       = lo_reg;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_control.sv
// Scoreboard bench for muldiv_control: expected MFHI/MFLO values are queued
// when a read is issued and matched by monitors whenever o_result_valid fires.
module tb_muldiv_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  aluop = 6'h00;
  logic [5:0]  func = 6'h00;
  logic [31:0] rs = 32'h0;
  logic [31:0] rt = 32'h0;

  logic        stall, busy, result_valid, unknown_func, div_by_zero;
  logic [31:0] result;

  logic        f_valid = 1'b0;
  logic        f_flush = 1'b0;
  logic [5:0]  f_aluop = 6'h00;
  logic [5:0]  f_func = 6'h00;
  logic [31:0] f_rs = 32'h0;
  logic [31:0] f_rt = 32'h0;
  logic        f_stall, f_busy, f_result_valid, f_unknown_func, f_div_by_zero;
  logic [31:0] f_result;

  int checks = 0;
  int failures = 0;
  int dz_seen = 0;

  logic [31:0] exp_val[$];
  string       exp_name[$];
  logic [31:0] f_exp_val[$];
  string       f_exp_name[$];

  always #5 clk = ~clk;

  muldiv_control #(.DATA_W(32), .FAST_MUL(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_aluOp(aluop), .i_func(func),
    .i_rs(rs), .i_rt(rt), .i_flush(flush),
    .o_stall(stall), .o_busy(busy), .o_result(result), .o_result_valid(result_valid),
    .o_unknown_func(unknown_func), .o_div_by_zero(div_by_zero)
  );

  muldiv_control #(.DATA_W(32), .FAST_MUL(1)) dut_fast (
    .i_clk(clk), .i_rst(rst), .i_valid(f_valid), .i_aluOp(f_aluop), .i_func(f_func),
    .i_rs(f_rs), .i_rt(f_rt), .i_flush(f_flush),
    .o_stall(f_stall), .o_busy(f_busy), .o_result(f_result), .o_result_valid(f_result_valid),
    .o_unknown_func(f_unknown_func), .o_div_by_zero(f_div_by_zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor for the iterative instance: pop one expectation per read
  always @(negedge clk) begin : mon_main
    string       n;
    logic [31:0] v;
    if (!rst && result_valid) begin
      if (exp_val.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got %h want none", result);
      end else begin
        n = exp_name.pop_front();
        v = exp_val.pop_front();
        check(n, 64'(result), 64'(v));
      end
    end
    if (!rst && div_by_zero) dz_seen++;
  end

  // Monitor for the single-cycle-multiply instance
  always @(negedge clk) begin : mon_fast
    string       n;
    logic [31:0] v;
    if (!rst && f_result_valid) begin
      if (f_exp_val.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_fast_result: got %h want none", f_result);
      end else begin
        n = f_exp_name.pop_front();
        v = f_exp_val.pop_front();
        check(n, 64'(f_result), 64'(v));
      end
    end
  end

  // Read HI or LO once the engine is idle; the monitor checks the value
  task automatic mf(input logic [5:0] fn, input logic [31:0] e, input string n);
    exp_val.push_back(e);
    exp_name.push_back(n);
    @(posedge clk); #1;
    valid = 1'b1; aluop = 6'h00; func = fn;
    @(negedge clk);
    check({n, "_nostall"}, 64'(stall), 64'd0);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  // Issue a single-cycle instruction (MTHI/MTLO)
  task automatic issue(input logic [5:0] fn, input logic [31:0] a);
    @(posedge clk); #1;
    valid = 1'b1; aluop = 6'h00; func = fn; rs = a;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  // Issue MULT*/DIV*, count busy cycles; optionally hold an MFLO behind it
  task automatic run_op(input string n, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy, input bit mf_during);
    int busy_cnt;
    bit done;
    @(posedge clk); #1;
    valid = 1'b1; aluop = 6'h00; func = fn; rs = a; rt = b;
    @(posedge clk); #1;
    if (mf_during) func = 6'h12;
    else valid = 1'b0;
    busy_cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
      end else begin
        busy_cnt++;
        if (mf_during && !stall) check({n, "_stall_during_busy"}, 64'(stall), 64'd1);
        @(posedge clk); #1;
      end
    end
    if (mf_during) begin
      @(posedge clk); #1;
      valid = 1'b0;
    end
    check({n, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
  endtask

  initial begin : stim
    int dz0;
    int fb;
    bit fdone;

    // Reset state
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_result_valid", 64'(result_valid), 64'd0);
    check("reset_unknown", 64'(unknown_func), 64'd0);
    check("reset_dz", 64'(div_by_zero), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mf(6'h10, 32'h0, "reset_hi");
    mf(6'h12, 32'h0, "reset_lo");

    // MULTU with an MFLO stalled behind it
    exp_val.push_back(32'hFFFFFFFE);
    exp_name.push_back("multu_lo_after_stall");
    run_op("multu", 6'h19, 32'hFFFFFFFF, 32'h2, 33, 1'b1);
    mf(6'h10, 32'h1, "multu_hi");

    // Signed multiply
    run_op("mult", 6'h18, 32'hFFFFFFFD, 32'h5, 33, 1'b0);
    mf(6'h10, 32'hFFFFFFFF, "mult_hi");
    mf(6'h12, 32'hFFFFFFF1, "mult_lo");

    run_op("mult_neg_neg", 6'h18, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0);
    mf(6'h10, 32'h0, "mult_nn_hi");
    mf(6'h12, 32'h1, "mult_nn_lo");

    run_op("multu_big", 6'h19, 32'h80000000, 32'h80000000, 33, 1'b0);
    mf(6'h10, 32'h40000000, "multu_big_hi");
    mf(6'h12, 32'h0, "multu_big_lo");

    // Signed divides
    run_op("div", 6'h1A, 32'hFFFFFFF9, 32'h2, 33, 1'b0);
    mf(6'h12, 32'hFFFFFFFD, "div_lo");
    mf(6'h10, 32'hFFFFFFFF, "div_hi");

    run_op("div_pos_neg", 6'h1A, 32'h7, 32'hFFFFFFFE, 33, 1'b0);
    mf(6'h12, 32'hFFFFFFFD, "div_pn_lo");
    mf(6'h10, 32'h1, "div_pn_hi");

    run_op("div_minint", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 33, 1'b0);
    mf(6'h12, 32'h80000000, "div_minint_lo");
    mf(6'h10, 32'h0, "div_minint_hi");

    run_op("divu", 6'h1B, 32'd100, 32'd7, 33, 1'b0);
    mf(6'h12, 32'd14, "divu_lo");
    mf(6'h10, 32'd2, "divu_hi");

    // Divide by zero
    dz0 = dz_seen;
    run_op("divu_zero", 6'h1B, 32'd9, 32'd0, 1, 1'b0);
    check("divu_zero_pulses", 64'(dz_seen - dz0), 64'd1);
    mf(6'h12, 32'hFFFFFFFF, "divu_zero_lo");
    mf(6'h10, 32'd9, "divu_zero_hi");

    // MTHI then flushed MULT: HI/LO keep their values
    issue(6'h11, 32'hA5A5A5A5);
    @(posedge clk); #1;
    valid = 1'b1; aluop = 6'h00; func = 6'h18; rs = 32'h3; rt = 32'h7;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'd0);
    mf(6'h10, 32'hA5A5A5A5, "flush_hi");
    mf(6'h12, 32'hFFFFFFFF, "flush_lo");

    // Reset in the middle of a DIVU
    @(posedge clk); #1;
    valid = 1'b1; aluop = 6'h00; func = 6'h1B; rs = 32'd100; rt = 32'd7;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst_mid_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mf(6'h10, 32'h0, "rst_mid_hi");
    mf(6'h12, 32'h0, "rst_mid_lo");

    // Unknown func in the 6'b01xxxx group has no effect
    @(posedge clk); #1;
    valid = 1'b1; aluop = 6'h00; func = 6'h1C; rs = 32'h5; rt = 32'h1;
    @(negedge clk);
    check("unknown_func", 64'(unknown_func), 64'd1);
    check("unknown_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    aluop = 6'h01;
    @(negedge clk);
    check("unknown_other_opcode", 64'(unknown_func), 64'd0);
    @(posedge clk); #1;
    valid = 1'b0; aluop = 6'h00;
    @(negedge clk);
    check("unknown_busy", 64'(busy), 64'd0);
    mf(6'h10, 32'h0, "unknown_hi");

    // Single-cycle multiply instance
    @(posedge clk); #1;
    f_valid = 1'b1; f_aluop = 6'h00; f_func = 6'h18; f_rs = 32'hFFFFFFFD; f_rt = 32'h5;
    @(posedge clk); #1;
    f_valid = 1'b0;
    fb = 0;
    fdone = 1'b0;
    for (int i = 0; i < 100 && !fdone; i++) begin
      @(negedge clk);
      if (!f_busy) fdone = 1'b1;
      else begin
        fb++;
        @(posedge clk); #1;
      end
    end
    check("fast_mult_busy_cycles", 64'(fb), 64'd1);
    f_exp_val.push_back(32'hFFFFFFFF);
    f_exp_name.push_back("fast_mult_hi");
    f_exp_val.push_back(32'hFFFFFFF1);
    f_exp_name.push_back("fast_mult_lo");
    @(posedge clk); #1;
    f_valid = 1'b1; f_func = 6'h10;
    @(posedge clk); #1;
    f_func = 6'h12;
    @(posedge clk); #1;
    f_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Every queued read was observed; exactly one div-by-zero pulse overall
    check("pending_reads", 64'(exp_val.size()), 64'd0);
    check("pending_fast_reads", 64'(f_exp_val.size()), 64'd0);
    check("total_dz_pulses", 64'(dz_seen), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
